// File: rtl/scan2000_ctrl.sv
// Keithley 2000-SCAN relay controller emulation: synchronizes the DMM's 3-wire
// relay bus, shifts coil words and latches set/reset commands into 20 relays.
module scan2000_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_SYS,
    input  logic RST,
    input  logic CLK_DMM,
    input  logic DATA_DMM,
    input  logic STROBE_DMM,
    input  logic CH20_mode_enable,
    output logic CH1,
    output logic CH2,
    output logic CH3,
    output logic CH4,
    output logic CH5,
    output logic CH6,
    output logic CH7,
    output logic CH8,
    output logic CH9,
    output logic CH10,
    output logic CH11,
    output logic CH12,
    output logic CH13,
    output logic CH14,
    output logic CH15,
    output logic CH16,
    output logic CH17,
    output logic CH18,
    output logic CH19,
    output logic CH20,
    output logic Bus2_sense_enable,
    output logic Bus2_input_enable
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0] strb_sync_q, strb_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   strb_prev_q, strb_prev_d;
    logic [47:0]            shreg_q, shreg_d;
    logic [19:0]            relay_q, relay_d;
    logic                   fourwire_q, fourwire_d;
    logic [19:0]            ch_q, ch_d;
    logic                   sense_q, sense_d;
    logic                   input_q, input_d;

    logic        clk_fall, strb_rise, bank2_any;
    logic [19:0] set_v, rst_v;
    logic        fw_set, fw_rst;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], CLK_DMM};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], DATA_DMM};
        strb_sync_d = {strb_sync_q[SYNC_STAGES-2:0], STROBE_DMM};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        strb_prev_d = strb_sync_q[SYNC_STAGES-1];
        clk_fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        strb_rise   = ~strb_prev_q & strb_sync_q[SYNC_STAGES-1];
    end

    // Decode from the post-shift value so a strobe coincident with a clock
    // edge sees the bit that edge delivers.
    always_comb begin
        shreg_d = shreg_q;
        if (clk_fall)
            shreg_d = {shreg_q[46:0], data_sync_q[SYNC_STAGES-1]};

        set_v  = '0;
        rst_v  = '0;
        fw_set = 1'b0;
        fw_rst = 1'b0;
        if (CH20_mode_enable) begin
            for (int i = 0; i < 10; i++) begin
                set_v[i]      = shreg_d[2*i+21];
                rst_v[i]      = shreg_d[2*i+20];
                set_v[10+i]   = shreg_d[2*i+1];
                rst_v[10+i]   = shreg_d[2*i];
            end
            fw_set = shreg_d[41];
            fw_rst = shreg_d[40];
        end else begin
            set_v[0]  = shreg_d[16];  rst_v[0]  = shreg_d[17];
            set_v[1]  = shreg_d[18];  rst_v[1]  = shreg_d[19];
            set_v[2]  = shreg_d[20];  rst_v[2]  = shreg_d[21];
            set_v[3]  = shreg_d[22];  rst_v[3]  = shreg_d[23];
            set_v[4]  = shreg_d[9];   rst_v[4]  = shreg_d[8];
            set_v[10] = shreg_d[13];  rst_v[10] = shreg_d[4];
            set_v[11] = shreg_d[15];  rst_v[11] = shreg_d[14];
            set_v[12] = shreg_d[1];   rst_v[12] = shreg_d[0];
            set_v[13] = shreg_d[3];   rst_v[13] = shreg_d[2];
            set_v[14] = shreg_d[6];   rst_v[14] = shreg_d[5];
            fw_set    = shreg_d[11];
            fw_rst    = shreg_d[12];
        end

        relay_d    = relay_q;
        fourwire_d = fourwire_q;
        if (strb_rise) begin
            relay_d    = (relay_q | set_v) & ~rst_v;
            fourwire_d = (fourwire_q | fw_set) & ~fw_rst;
        end

        bank2_any = |relay_q[19:10];
        ch_d      = relay_q;
        sense_d   = fourwire_q & bank2_any;
        input_d   = ~fourwire_q & bank2_any;
    end

    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            strb_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            strb_prev_q <= 1'b0;
            shreg_q     <= '0;
            relay_q     <= '0;
            fourwire_q  <= 1'b0;
            ch_q        <= '0;
            sense_q     <= 1'b0;
            input_q     <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            strb_sync_q <= strb_sync_d;
            clk_prev_q  <= clk_prev_d;
            strb_prev_q <= strb_prev_d;
            shreg_q     <= shreg_d;
            relay_q     <= relay_d;
            fourwire_q  <= fourwire_d;
            ch_q        <= ch_d;
            sense_q     <= sense_d;
            input_q     <= input_d;
        end
    end

    assign {CH20, CH19, CH18, CH17, CH16, CH15, CH14, CH13, CH12, CH11,
            CH10, CH9, CH8, CH7, CH6, CH5, CH4, CH3, CH2, CH1} = ch_q;
    assign Bus2_sense_enable = sense_q;
    assign Bus2_input_enable = input_q;

endmodule

// File: tb/tb_scan2000_ctrl.sv
// Directed + randomized bench for scan2000_ctrl against a bit-queue relay model.
module tb_scan2000_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic clk = 1'b0;
    logic rst, dclk, ddata, dstrb, mode;
    logic [19:0] ch;
    logic sense, inp;

    int ncmp  = 0;
    int nfail = 0;

    // reference model state
    bit   bits_q[$];
    bit   m_relay[20];
    bit   m_fw;

    // 10-channel scanner table: relay index, set bit, reset bit
    int t_ch [10] = '{0, 1, 2, 3, 4, 10, 11, 12, 13, 14};
    int t_set[10] = '{16, 18, 20, 22, 9, 13, 15, 1, 3, 6};
    int t_rst[10] = '{17, 19, 21, 23, 8, 4, 14, 0, 2, 5};

    always #5 clk = ~clk;

    scan2000_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK_SYS(clk), .RST(rst), .CLK_DMM(dclk), .DATA_DMM(ddata),
        .STROBE_DMM(dstrb), .CH20_mode_enable(mode),
        .CH1(ch[0]),   .CH2(ch[1]),   .CH3(ch[2]),   .CH4(ch[3]),   .CH5(ch[4]),
        .CH6(ch[5]),   .CH7(ch[6]),   .CH8(ch[7]),   .CH9(ch[8]),   .CH10(ch[9]),
        .CH11(ch[10]), .CH12(ch[11]), .CH13(ch[12]), .CH14(ch[13]), .CH15(ch[14]),
        .CH16(ch[15]), .CH17(ch[16]), .CH18(ch[17]), .CH19(ch[18]), .CH20(ch[19]),
        .Bus2_sense_enable(sense), .Bus2_input_enable(inp)
    );

    function automatic bit wbit(int idx);
        // bit idx of the word = idx-th most recent bit shifted in
        if (idx >= bits_q.size()) return 1'b0;
        return bits_q[bits_q.size() - 1 - idx];
    endfunction

    function automatic void apply_rule(int r, bit s, bit c);
        if (c) m_relay[r] = 1'b0;
        else if (s) m_relay[r] = 1'b1;
    endfunction

    function automatic void model_commit();
        bit s, c;
        if (mode) begin
            for (int n = 1; n <= 10; n++) apply_rule(n - 1, wbit(2*n + 19), wbit(2*n + 18));
            for (int m = 1; m <= 10; m++) apply_rule(9 + m, wbit(2*m - 1), wbit(2*m - 2));
            s = wbit(41); c = wbit(40);
        end else begin
            for (int k = 0; k < 10; k++) apply_rule(t_ch[k], wbit(t_set[k]), wbit(t_rst[k]));
            s = wbit(11); c = wbit(12);
        end
        if (c) m_fw = 1'b0;
        else if (s) m_fw = 1'b1;
    endfunction

    function automatic logic [21:0] model_out();
        logic [21:0] v;
        bit any2;
        v = '0;
        any2 = 1'b0;
        for (int i = 0; i < 20; i++) v[i] = m_relay[i];
        for (int i = 10; i < 20; i++) any2 = any2 | m_relay[i];
        v[20] = m_fw && any2;
        v[21] = !m_fw && any2;
        return v;
    endfunction

    function automatic logic [21:0] dut_out();
        return {inp, sense, ch};
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(bit b, bit strobe_on_fall);
        ddata = b;
        dclk  = 1'b1;
        cyc(HALF);
        dclk  = 1'b0;
        bits_q.push_back(b);
        if (bits_q.size() > 64) void'(bits_q.pop_front());
        if (strobe_on_fall) dstrb = 1'b1;
        cyc(HALF);
    endtask

    task automatic strobe();
        dstrb = 1'b1;
        cyc(HALF);
    endtask

    // Sample exactly SYNC_STAGES+3 cycles after the strobe rising edge.
    task automatic send_word(logic [47:0] w, bit coincide);
        int n;
        n = mode ? 48 : 24;
        for (int i = n - 1; i >= 0; i--) send_bit(w[i], coincide && i == 0);
        if (!coincide) dstrb = 1'b1;
        cyc(SYNC_STAGES + 3 - (coincide ? HALF : 0));
        model_commit();
    endtask

    task automatic finish_strobe();
        dstrb = 1'b0;
        cyc(HALF);
    endtask

    task automatic chk_model(string tag);
        logic [21:0] got, exp;
        got = dut_out();
        exp = model_out();
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_const(string tag, logic [21:0] exp);
        logic [21:0] got;
        got = dut_out();
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(logic [47:0] w, logic [21:0] exp, string tag);
        send_word(w, 1'b0);
        chk_const(tag, exp);
        chk_model({tag, "_m"});
        finish_strobe();
    endtask

    // Step followed by an all-zero coil-off word that must change nothing.
    task automatic step_z(logic [47:0] w, logic [21:0] exp, string tag);
        step(w, exp, tag);
        step(48'h0, exp, {tag, "_z"});
    endtask

    task automatic do_reset(bit md);
        rst = 1'b1; mode = md;
        cyc(4);
        bits_q.delete();
        foreach (m_relay[i]) m_relay[i] = 1'b0;
        m_fw = 1'b0;
        chk_const("reset", 22'h0);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic random_run(int cnt, string tag);
        logic [47:0] w;
        for (int k = 0; k < cnt; k++) begin
            w = {$urandom, $urandom} & {$urandom, $urandom};
            for (int r = $urandom_range(0, 3); r > 0; r--) send_bit(1'($urandom), 1'b0);
            send_word(w, 1'($urandom_range(0, 3) == 0));
            chk_model(tag);
            finish_strobe();
        end
    endtask

    initial begin
        dclk = 1'b0; ddata = 1'b0; dstrb = 1'b0; rst = 1'b1; mode = 1'b0;
        cyc(2);

        // ---- 10-channel format ----
        do_reset(1'b0);
        step(48'hAA55B5, 22'h0, "m0_rst_word");
        step(48'hAA4DB5, 22'h0, "m0_fw_nobank2");
        step(48'h001480, 22'h0, "m0_001480");
        step(48'h011480, 22'h000001, "m0_ch1");
        step(48'h020480, 22'h0, "m0_ch1_off");
        step(48'h000480, 22'h0, "m0_nochange");
        step(48'h040480, 22'h000002, "m0_ch2");
        step(48'hAA45B5, 22'h0, "m0_clear");
        step(48'h012C80, 22'h100401, "m0_sense");
        step(48'hAA45B5, 22'h0, "m0_clear_fwkeep");
        step(48'h000480, 22'h0, "m0_zero2");
        step(48'h0014C0, 22'h204000, "m0_input");

        // rogue bits with no strobe must not disturb the next decode
        step(48'hAA55B5, 22'h0, "m0_pre_rogue");
        step(48'h011480, 22'h000001, "m0_rogue_ch1");
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        step(48'h001480, 22'h000001, "m0_rogue_hold");
        step(48'h020480, 22'h0, "m0_rogue_off");

        // strobe on the same edge as the final shift
        send_word(48'h011480, 1'b1);
        cyc(HALF);
        chk_const("m0_coincide", 22'h000001);
        chk_model("m0_coincide_m");
        finish_strobe();

        random_run(40, "m0_rand");

        // ---- 20-channel format ----
        do_reset(1'b1);
        step_z(48'h015555555555, 22'h0, "m1_rst_word");
        step_z(48'h000000200000, 22'h000001, "m1_ch1");
        step_z(48'h000000100000, 22'h0, "m1_ch1_off");
        step_z(48'h000000800000, 22'h000002, "m1_ch2");
        step(48'h015555555555, 22'h0, "m1_rst2");
        step_z(48'h020000200002, 22'h100401, "m1_sense1");
        step(48'h015555555555, 22'h0, "m1_rst3");
        step_z(48'h020000800008, 22'h100802, "m1_sense2");
        step_z(48'h000000400004, 22'h0, "m1_fw_keep");
        step_z(48'h008000080000, 22'h180200, "m1_ch10_20");
        step_z(48'h010000040000, 22'h000200, "m1_ch10_only");

        random_run(40, "m1_rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
